// File: rtl/spi_config_pkg.sv
// Shared SPI definitions for the configuration master and the FIR config receive side.
// Mode 0: clock idles low, data sampled on the rising edge and launched on the falling edge.
package spi_config_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    NEXT,
    HOLD,
    GAP
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

endpackage

// File: rtl/spi_config_master.sv
// SPI mode-0 master: frames valid/ready words under cs and shifts them MSB-first.
// spiClk/cs/mosi are registered; wordReady depends on state only and is high in IDLE and NEXT.
module spi_config_master
  import spi_config_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wordData,
  input  logic                  wordLast,
  input  logic                  wordValid,
  output logic                  wordReady,
  output logic                  spiClk,
  output logic                  cs,
  output logic                  mosi,
  output logic                  busy,
  output logic                  frameDone
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          CLK_IDLE = SPI_MODE0[1];

  spi_state_t            r_state;
  spi_state_t            w_next;
  logic [PW-1:0]         r_phase;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_last;
  logic                  r_armed;
  logic                  r_sclk;
  logic                  r_cs;
  logic                  r_frame_done;
  logic                  w_ready;
  logic                  w_phase_end;
  logic                  w_load;

  assign w_phase_end = (r_phase == PH_LAST);
  assign w_load      = w_ready & wordValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_armed keeps wordReady low until the first edge after reset release.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = r_armed;
        if (wordValid && r_armed) w_next = LOW;
      end
      LOW: begin
        if (w_phase_end) w_next = HIGH;
      end
      HIGH: begin
        if (w_phase_end) begin
          if (r_bit != BIT_LAST) w_next = LOW;
          else if (r_last)       w_next = HOLD;
          else                   w_next = NEXT;
        end
      end
      NEXT: begin
        w_ready = 1'b1;
        if (wordValid) w_next = LOW;
      end
      HOLD: begin
        if (w_phase_end) w_next = GAP;
      end
      GAP: begin
        if (w_phase_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Pins are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase      <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_last       <= 1'b0;
      r_armed      <= 1'b0;
      r_sclk       <= CLK_IDLE;
      r_cs         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_armed      <= 1'b1;
      r_phase      <= (w_next != r_state) ? '0 : r_phase + 1'b1;
      r_sclk       <= (w_next == HIGH) ? ~CLK_IDLE : CLK_IDLE;
      r_cs         <= (w_next == IDLE) || (w_next == GAP);
      r_frame_done <= (r_state == HOLD) && w_phase_end;
      if (w_load) begin
        r_shift <= wordData;
        r_last  <= wordLast;
        r_bit   <= '0;
      end else if ((r_state == HIGH) && w_phase_end && (r_bit != BIT_LAST)) begin
        r_shift <= r_shift << 1;
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  assign wordReady = w_ready;
  assign spiClk    = r_sclk;
  assign cs        = r_cs;
  assign mosi      = r_shift[DATA_WIDTH-1];
  assign busy      = (r_state != IDLE);
  assign frameDone = r_frame_done;

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: two instances (16-bit/H=4 and 8-bit/H=1) checked every cycle
// against a timeline model of the serial frame, plus literal frame-level expectations.
module tb_spi_config_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld   [2];
  logic [15:0] dat   [2];
  logic        lst   [2];
  logic        cs_o  [2];
  logic        sclk_o[2];
  logic        mosi_o[2];
  logic        rdy_o [2];
  logic        busy_o[2];
  logic        fd_o  [2];

  spi_config_master #(.DATA_WIDTH(16), .CLK_DIV(4)) u_dut0 (
    .clk(clk), .reset(rst), .wordData(dat[0]), .wordLast(lst[0]), .wordValid(vld[0]),
    .wordReady(rdy_o[0]), .spiClk(sclk_o[0]), .cs(cs_o[0]), .mosi(mosi_o[0]),
    .busy(busy_o[0]), .frameDone(fd_o[0])
  );

  spi_config_master #(.DATA_WIDTH(8), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst), .wordData(dat[1][7:0]), .wordLast(lst[1]), .wordValid(vld[1]),
    .wordReady(rdy_o[1]), .spiClk(sclk_o[1]), .cs(cs_o[1]), .mosi(mosi_o[1]),
    .busy(busy_o[1]), .frameDone(fd_o[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: m_k counts cycles into the current word (-1 when not shifting),
  // m_tail counts cycles after a final word (-1 when none), m_wait marks a frame open between words.
  int          HP [2] = '{4, 1};
  int          DWP[2] = '{16, 8};
  logic [15:0] m_word [2];
  bit          m_last [2];
  int          m_k    [2];
  bit          m_wait [2];
  int          m_tail [2];
  bit          m_armed[2];

  function automatic void model_out(input int i, output bit e_cs, output bit e_sclk,
                                    output bit e_mosi, output bit e_rdy, output bit e_busy,
                                    output bit e_fd);
    int h, dw;
    h = HP[i];
    dw = DWP[i];
    e_cs = 1'b1; e_sclk = 1'b0; e_mosi = m_word[i][0]; e_rdy = 1'b0; e_busy = 1'b0; e_fd = 1'b0;
    if (m_k[i] >= 0) begin
      e_cs   = 1'b0;
      e_busy = 1'b1;
      e_sclk = (m_k[i] % (2 * h)) >= h;
      e_mosi = m_word[i][dw - 1 - m_k[i] / (2 * h)];
    end else if (m_wait[i]) begin
      e_cs   = 1'b0;
      e_busy = 1'b1;
      e_rdy  = 1'b1;
    end else if (m_tail[i] >= 0) begin
      e_busy = 1'b1;
      e_cs   = (m_tail[i] >= h);
      e_fd   = (m_tail[i] == h);
    end else begin
      e_rdy = m_armed[i];
    end
  endfunction

  initial forever begin
    bit a, b, c, r, d, f;
    int h, dw;
    logic [15:0] mask;
    @(posedge clk or posedge rst);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_word[i] = '0; m_last[i] = 1'b0; m_k[i] = -1; m_wait[i] = 1'b0;
        m_tail[i] = -1; m_armed[i] = 1'b0;
      end else begin
        h = HP[i];
        dw = DWP[i];
        mask = 16'((32'd1 << dw) - 1);
        model_out(i, a, b, c, r, d, f);
        if (vld[i] && r) begin
          m_word[i] = dat[i] & mask;
          m_last[i] = lst[i];
          m_k[i]    = 0;
          m_wait[i] = 1'b0;
          m_tail[i] = -1;
        end else if (m_k[i] >= 0) begin
          m_k[i]++;
          if (m_k[i] == 2 * h * dw) begin
            m_k[i] = -1;
            if (m_last[i]) m_tail[i] = 0;
            else           m_wait[i] = 1'b1;
          end
        end else if (m_tail[i] >= 0) begin
          m_tail[i]++;
          if (m_tail[i] == 2 * h) m_tail[i] = -1;
        end
        m_armed[i] = 1'b1;
      end
    end
  end

  // Compare process: every output of both instances, every cycle.
  initial forever begin
    bit e_cs, e_sclk, e_mosi, e_rdy, e_busy, e_fd;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_out(i, e_cs, e_sclk, e_mosi, e_rdy, e_busy, e_fd);
      check($sformatf("cs[%0d]", i),        32'(cs_o[i]),   32'(e_cs));
      check($sformatf("spiClk[%0d]", i),    32'(sclk_o[i]), 32'(e_sclk));
      check($sformatf("mosi[%0d]", i),      32'(mosi_o[i]), 32'(e_mosi));
      check($sformatf("wordReady[%0d]", i), 32'(rdy_o[i]),  32'(e_rdy));
      check($sformatf("busy[%0d]", i),      32'(busy_o[i]), 32'(e_busy));
      check($sformatf("frameDone[%0d]", i), 32'(fd_o[i]),   32'(e_fd));
    end
  end

  // Frame-level observation: bits captured at spiClk rises, cs low cycles, pulses.
  logic        clr   [2];
  int          rises [2];
  logic [31:0] cap   [2];
  int          cslow [2];
  int          csrise[2];
  int          fdcnt [2];
  logic        psclk [2];
  logic        pcs   [2];

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        rises[i] = 0; cap[i] = '0; cslow[i] = 0; csrise[i] = 0; fdcnt[i] = 0;
      end else begin
        if (sclk_o[i] === 1'b1 && psclk[i] !== 1'b1) begin
          rises[i]++;
          cap[i] = {cap[i][30:0], mosi_o[i]};
        end
        if (cs_o[i] === 1'b0) cslow[i]++;
        if (cs_o[i] === 1'b1 && pcs[i] === 1'b0) csrise[i]++;
        if (fd_o[i] === 1'b1) fdcnt[i]++;
      end
      psclk[i] = sclk_o[i];
      pcs[i]   = cs_o[i];
    end
  end

  task automatic clear_mon(input int i);
    clr[i] = 1'b1;
    @(negedge clk);
    #1 clr[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [15:0] d, input bit last);
    bit seen;
    int n;
    vld[i] = 1'b1; dat[i] = d; lst[i] = last;
    seen = 1'b0;
    n = 0;
    do begin
      seen = rdy_o[i];
      @(posedge clk);
      #1;
      n++;
    end while (!seen && n < 3000);
    check($sformatf("handshake_in_time[%0d]", i), 32'(seen), 32'd1);
    vld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while ((busy_o[i] !== 1'b0 || rdy_o[i] !== 1'b1) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("idle_in_time[%0d]", i), 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_next(input int i);
    int n;
    n = 0;
    while (rdy_o[i] !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("next_in_time[%0d]", i), 32'(n < 3000), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time %0t reached limit 900000 without finishing", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i, nw, n;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; dat[k] = '0; lst[k] = 1'b0; clr[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs",        32'(cs_o[0]),   32'd1);
    check("rst_spiClk",    32'(sclk_o[0]), 32'd0);
    check("rst_mosi",      32'(mosi_o[0]), 32'd0);
    check("rst_wordReady", 32'(rdy_o[0]),  32'd0);
    check("rst_busy",      32'(busy_o[0]), 32'd0);
    check("rst_frameDone", 32'(fd_o[0]),   32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_release0", 32'(rdy_o[0]), 32'd1);
    check("ready_after_release1", 32'(rdy_o[1]), 32'd1);

    // 8-bit word at H=1: 16 cycles of bits plus one HOLD cycle under cs.
    clear_mon(1);
    send(1, 16'h005A, 1'b1);
    wait_idle(1);
    check("h1_bits",     cap[1],        32'h0000005A);
    check("h1_rises",    32'(rises[1]), 32'd8);
    check("h1_cs_low",   32'(cslow[1]), 32'd17);
    check("h1_frameDone",32'(fdcnt[1]), 32'd1);

    // Single default word: cs low 16*8 + 4 cycles.
    clear_mon(0);
    send(0, 16'hA5C3, 1'b1);
    wait_idle(0);
    check("a5c3_bits",      cap[0],        32'h0000A5C3);
    check("a5c3_rises",     32'(rises[0]), 32'd16);
    check("a5c3_cs_low",    32'(cslow[0]), 32'd132);
    check("a5c3_frameDone", 32'(fdcnt[0]), 32'd1);

    // Three words with valid held: one NEXT cycle between words.
    clear_mon(0);
    send(0, 16'h0001, 1'b0);
    send(0, 16'h8000, 1'b0);
    send(0, 16'hFFFF, 1'b1);
    wait_idle(0);
    check("multi_rises",     32'(rises[0]),  32'd48);
    check("multi_bits",      cap[0],         32'h8000FFFF);
    check("multi_cs_low",    32'(cslow[0]),  32'd390);
    check("multi_cs_rise",   32'(csrise[0]), 32'd1);
    check("multi_frameDone", 32'(fdcnt[0]),  32'd1);

    // 50-cycle stall inside the frame.
    clear_mon(0);
    send(0, 16'h1234, 1'b0);
    wait_next(0);
    repeat (50) @(posedge clk);
    #1;
    send(0, 16'hC001, 1'b1);
    wait_idle(0);
    check("stall_bits",      cap[0],         32'h1234C001);
    check("stall_cs_rise",   32'(csrise[0]), 32'd1);
    check("stall_frameDone", 32'(fdcnt[0]),  32'd1);

    // Reset in the middle of a word, after the eighth rise.
    clear_mon(0);
    send(0, 16'hBEEF, 1'b1);
    n = 0;
    while (rises[0] < 8 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_cs",        32'(cs_o[0]),   32'd1);
    check("midrst_spiClk",    32'(sclk_o[0]), 32'd0);
    check("midrst_mosi",      32'(mosi_o[0]), 32'd0);
    check("midrst_wordReady", 32'(rdy_o[0]),  32'd0);
    check("midrst_busy",      32'(busy_o[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_frameDone", 32'(fdcnt[0]), 32'd0);
    check("midrst_rises",        32'(rises[0]), 32'd8);
    clear_mon(0);
    send(0, 16'h3C96, 1'b1);
    wait_idle(0);
    check("after_rst_bits",      cap[0],        32'h00003C96);
    check("after_rst_frameDone", 32'(fdcnt[0]), 32'd1);

    // Randomised frames; stray valid during HOLD/GAP when frames are sent back to back.
    for (int f = 0; f < 30; f++) begin
      i  = (f % 5 == 4) ? 1 : 0;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        if (w > 0 && $urandom_range(0, 2) == 0) begin
          wait_next(i);
          repeat ($urandom_range(1, 20)) @(posedge clk);
          #1;
        end
        send(i, 16'($urandom), (w == nw - 1));
      end
      if ($urandom_range(0, 1) == 1) wait_idle(i);
    end
    wait_idle(0);
    wait_idle(1);
    repeat (5) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
